// File: rtl/pipeline_stage_skid_pkg.sv
// Shared pipeline definitions: skid stage state encoding and occupancy constants.
// The helper maps a stage state to its visible entry count.
package pipeline_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_BUSY  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occupancy_of(input skid_state_e s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            ST_EMPTY: occ = OCC_EMPTY;
            ST_BUSY:  occ = OCC_BUSY;
            ST_FULL:  occ = OCC_FULL;
            default:  occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipeline_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != COUNT_MAX)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stage_skid.sv
// Two-entry skid buffer pipeline stage with registered valid/ready, flush,
// and a saturating backpressure stall counter.
module pipeline_stage_skid
    import pipeline_stage_skid_pkg::*;
#(
    parameter int unsigned PAYLOAD_W      = 64,
    parameter bit          CLEAR_ON_FLUSH = 1'b0,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_flush,
    input  logic                   i_cnt_clr,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [PAYLOAD_W-1:0]   i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PAYLOAD_W-1:0]   o_data,
    output logic [1:0]             o_occupancy,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    // Handshake: a payload moves on a rising edge where valid and ready are both
    // high on the same side. o_valid/o_ready come only from registered state, so
    // neither depends combinationally on i_valid or i_ready.

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, skid_q;
    logic                 in_xfer, out_xfer;
    logic                 load_main_in, load_main_skid, load_skid, clear_payload;

    assign o_valid     = (state_q != ST_EMPTY);
    assign o_ready     = (state_q != ST_FULL);
    assign o_occupancy = occupancy_of(state_q);
    assign o_data      = main_q;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides every transition: same-cycle input is dropped, output counts as taken.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_payload  = 1'b0;
        if (i_flush) begin
            state_d       = ST_EMPTY;
            clear_payload = CLEAR_ON_FLUSH;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_main_in = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (clear_payload) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= i_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_data;
            end
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_clr  (i_cnt_clr),
        .i_en   (o_valid & ~i_ready),
        .o_count(o_stall_cnt)
    );

endmodule
